ula: RTL and testbench

- 32-bit integer ALU for the single-cycle RISC-V datapath; computes ADD, SUB, AND, OR on two operands selected by a 2-bit control code.
- Primary outputs (result, zero) are purely combinational, valid in the same cycle, and feed writeback and branch-compare logic.
- A registered copy of result plus a status-flag register (N, Z, C, V) is provided for debug and trace, clocked on clk with synchronous active-high reset.

---
 rtl/ula_pkg.sv | 18 +
 rtl/ula_addsub.sv | 29 ++
 rtl/ula.sv | 73 +++++++
 tb/tb_ula.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// Shared constants for the ula ALU: operation codes, default width
// and bit positions inside the registered status-flag word.
package ula_pkg;

    localparam int ULA_WIDTH = 32;

    localparam logic [1:0] ULA_ADD = 2'b00;
    localparam logic [1:0] ULA_SUB = 2'b01;
    localparam logic [1:0] ULA_AND = 2'b10;
    localparam logic [1:0] ULA_OR  = 2'b11;

    // flags_q = {N, Z, C, V}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/ula_addsub.sv
// Shared adder/subtractor for ula: sum = a + (sub ? ~b + 1 : b).
// Ports: a, b operands; sub selects subtract; sum, carry (carry-out,
// i.e. no-borrow when subtracting), overflow (signed overflow).
module ula_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   wide;

    // Subtraction reuses the adder: invert b and inject the +1 as carry-in.
    assign b_eff = b ^ {WIDTH{sub}};
    assign wide  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};

    assign sum   = wide[WIDTH-1:0];
    assign carry = wide[WIDTH];

    // Signed overflow: addends share a sign the sum does not.
    assign overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) &&
                      (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/ula.sv
// ula: combinational ADD/SUB/AND/OR ALU with a registered trace copy.
// Ports: clk, rst (sync, active-high), op_a, op_b, control (2-bit op),
// result/zero/negative/carry/overflow (combinational),
// result_q and flags_q {N,Z,C,V} (registered, one cycle later).
module ula
    import ula_pkg::*;
#(
    parameter int WIDTH = ULA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [1:0]       control,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic [WIDTH-1:0] result_q,
    output logic [3:0]       flags_q
);

    logic [WIDTH-1:0] as_sum;
    logic             as_carry;
    logic             as_ovf;
    logic             sub;

    assign sub = (control == ULA_SUB);

    ula_addsub #(
        .WIDTH(WIDTH)
    ) u_addsub (
        .a       (op_a),
        .b       (op_b),
        .sub     (sub),
        .sum     (as_sum),
        .carry   (as_carry),
        .overflow(as_ovf)
    );

    always_comb begin
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        unique case (control)
            ULA_ADD, ULA_SUB: begin
                result   = as_sum;
                carry    = as_carry;
                overflow = as_ovf;
            end
            ULA_AND: result = op_a & op_b;
            ULA_OR:  result = op_a | op_b;
        endcase
    end

    assign zero     = ~|result;
    assign negative = result[WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            flags_q  <= 4'b0000;
        end else begin
            result_q        <= result;
            flags_q[FLAG_N] <= negative;
            flags_q[FLAG_Z] <= zero;
            flags_q[FLAG_C] <= carry;
            flags_q[FLAG_V] <= overflow;
        end
    end

endmodule

// File: tb/tb_ula.sv
// Scoreboard bench for ula: stimulus pushes model expectations,
// a monitor pops and compares one entry after every rising edge.
module tb_ula;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [1:0]  control = 2'b00;
    logic [31:0] result;
    logic        zero;
    logic        negative;
    logic        carry;
    logic        overflow;
    logic [31:0] result_q;
    logic [3:0]  flags_q;

    always #5 clk = ~clk;

    ula dut (
        .clk     (clk),
        .rst     (rst),
        .op_a    (op_a),
        .op_b    (op_b),
        .control (control),
        .result  (result),
        .zero    (zero),
        .negative(negative),
        .carry   (carry),
        .overflow(overflow),
        .result_q(result_q),
        .flags_q (flags_q)
    );

    typedef struct {
        logic [31:0] res;
        logic        n;
        logic        z;
        logic        c;
        logic        v;
        logic [31:0] rq;
        logic [3:0]  fq;
        logic        has_want;
        logic [31:0] want;
    } item_t;

    item_t exp_q[$];
    int    n_chk  = 0;
    int    n_fail = 0;

    // Reference: plain 64-bit integer arithmetic from the operation rules.
    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] ctl, output logic [31:0] res,
                         output logic n, output logic z,
                         output logic c, output logic v);
        longint ua, ub, us, sa, sb, ss;
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        c  = 1'b0;
        v  = 1'b0;
        case (ctl)
            2'b00: begin
                us  = ua + ub;
                ss  = sa + sb;
                res = us[31:0];
                c   = (us >= 64'sd4294967296);
                v   = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
            end
            2'b01: begin
                us  = ua - ub;
                ss  = sa - sb;
                res = us[31:0];
                c   = (ua >= ub);
                v   = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
            end
            2'b10: res = a & b;
            default: res = a | b;
        endcase
        z = (res == 32'd0);
        n = (res >= 32'h8000_0000);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    task automatic step(input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] ctl, input logic r,
                        input logic has_want, input logic [31:0] want);
        item_t it;
        @(negedge clk);
        op_a    = a;
        op_b    = b;
        control = ctl;
        rst     = r;
        model(a, b, ctl, it.res, it.n, it.z, it.c, it.v);
        it.rq       = r ? 32'd0 : it.res;
        it.fq       = r ? 4'b0000 : {it.n, it.z, it.c, it.v};
        it.has_want = has_want;
        it.want     = want;
        exp_q.push_back(it);
    endtask

    // Monitor: inputs change on negedge, so at posedge+1 the combinational
    // outputs still reflect them and the registers have just captured.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                item_t e;
                e = exp_q.pop_front();
                chk("result", result, e.res);
                chk("zero", {31'b0, zero}, {31'b0, e.z});
                chk("negative", {31'b0, negative}, {31'b0, e.n});
                chk("carry", {31'b0, carry}, {31'b0, e.c});
                chk("overflow", {31'b0, overflow}, {31'b0, e.v});
                chk("result_q", result_q, e.rq);
                chk("flags_q", {28'b0, flags_q}, {28'b0, e.fq});
                if (e.has_want)
                    chk("plan_result", result, e.want);
            end
        end
    end

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'h0000_0000;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'h7FFF_FFFF;
            3: v = 32'h8000_0000;
            4: v = 32'($urandom_range(0, 16));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        // Reset state
        step(32'd1, 32'd2, 2'b00, 1'b1, 1'b1, 32'd3);
        step(32'd1, 32'd2, 2'b00, 1'b1, 1'b1, 32'd3);
        // Directed plan
        step(32'd10, 32'd5, 2'b00, 1'b0, 1'b1, 32'd15);
        step(32'd10, 32'd3, 2'b01, 1'b0, 1'b1, 32'd7);
        step(32'd5, 32'd5, 2'b01, 1'b0, 1'b1, 32'd0);
        step(32'hF0F0F0F0, 32'h0FF00FF0, 2'b10, 1'b0, 1'b1, 32'h00F000F0);
        step(32'hF0F0F0F0, 32'h0FF00FF0, 2'b11, 1'b0, 1'b1, 32'hFFF0FFF0);
        step(32'h7FFFFFFF, 32'd1, 2'b00, 1'b0, 1'b1, 32'h80000000);
        step(32'd0, 32'd1, 2'b01, 1'b0, 1'b1, 32'hFFFFFFFF);
        step(32'hFFFFFFFF, 32'd1, 2'b00, 1'b0, 1'b1, 32'd0);
        // Mid-run reset: registers hold non-zero, then clear, then recapture
        step(32'h80000000, 32'h80000000, 2'b00, 1'b0, 1'b1, 32'd0);
        step(32'h12345678, 32'h1, 2'b00, 1'b1, 1'b1, 32'h12345679);
        step(32'h12345678, 32'h1, 2'b00, 1'b0, 1'b1, 32'h12345679);
        // Random
        for (int i = 0; i < 400; i++)
            step(pick(), pick(), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 19) == 0), 1'b0, 32'd0);
        @(negedge clk);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(negedge clk);
        if (exp_q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d entries left expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
